seq_pattern_tx: RTL and testbench



---
 rtl/seq_tx_pkg.sv | 19 +
 rtl/seq_bit_timer.sv | 29 ++
 rtl/seq_pattern_tx.sv | 116 +++++++++++
 tb/tb_seq_pattern_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DIV_W = 4;

    // Default stimulus: the "1011" sequence the loopback detector looks for.
    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1011;
    localparam int         DEFAULT_LEN     = 4;

    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period timer: a div+1 down-counter that flags the last cycle of each bit.
module seq_bit_timer
    import seq_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= div;
        end else if (en) begin
            r_cnt <= (r_cnt == '0) ? div : r_cnt - 1'b1;
        end
    end

    assign bit_end = en && (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter, MSB-first with programmable bit period.
// Continuous-loop mode is compiled in only when SEQ_TX_LOOP_EN is defined.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter  int PAT_W = 8,
    localparam int LEN_W = calc_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] div,
    input  logic             loop,
    output logic             ser_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;

    logic [LEN_W-1:0]   w_len_clamped;
    logic [IDX_W-1:0]   w_first_idx;
    logic [IDX_W-1:0]   w_last_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_accept;
    logic               w_loop;
    logic               w_bit_end;
    logic [DIV_W-1:0]   w_timer_div;

`ifdef SEQ_TX_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = loop & 1'b0;
`endif

    assign w_len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    assign w_first_idx   = IDX_W'(w_len_clamped - 1'b1);
    assign w_last_idx    = IDX_W'(r_len - 1'b1);
    assign w_next_idx    = r_idx - 1'b1;
    assign w_accept      = (r_state == IDLE) && start && (len != '0);

    // At acceptance the captured div is not yet valid, so load from the port.
    assign w_timer_div   = (r_state == IDLE) ? div : r_div;

    seq_bit_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (r_state == SHIFT),
        .load    (w_accept),
        .div     (w_timer_div),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_len      <= '0;
            r_div      <= '0;
            r_idx      <= '0;
            ser_out    <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    ser_out <= 1'b0;
                    busy    <= 1'b0;
                    if (w_accept) begin
                        r_pat      <= pattern;
                        r_len      <= w_len_clamped;
                        r_div      <= div;
                        r_idx      <= w_first_idx;
                        ser_out    <= pattern[w_first_idx];
                        bit_strobe <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_bit_end) begin
                        if (r_idx != '0) begin
                            r_idx      <= w_next_idx;
                            ser_out    <= r_pat[w_next_idx];
                            bit_strobe <= 1'b1;
                        end else if (w_loop) begin
                            r_idx      <= w_last_idx;
                            ser_out    <= r_pat[w_last_idx];
                            bit_strobe <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            ser_out    <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx, with a "1011" detector model for loopback.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] div;
    logic       loop;
    logic       ser_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    seq_pattern_tx #(.PAT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .div        (div),
        .loop       (loop),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the downstream "1011" detector: registered flag.
    logic [3:0] det_sh;
    logic       det_flag;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            det_sh   <= '0;
            det_flag <= 1'b0;
        end else begin
            det_sh   <= {det_sh[2:0], ser_out};
            det_flag <= ({det_sh[2:0], ser_out} == 4'b1011);
        end
    end

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [7:0] pattern;
        logic [3:0] len;
        logic [3:0] div;
        logic       exp_ser;
        logic       exp_stb;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];

`ifdef SEQ_TX_LOOP_EN
    localparam int N_PASS = 3;
`else
    localparam int N_PASS = 1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic s, input logic st,
                              input logic b, input logic d);
        check({tag, ".ser_out"},    ser_out,    s);
        check({tag, ".bit_strobe"}, bit_strobe, st);
        check({tag, ".busy"},       busy,       b);
        check({tag, ".done"},       done,       d);
    endtask

    initial begin
        logic [7:0] exp_pat;
        logic [3:0] loop_bits;
        int         flag_hits;

        // rst, start, pattern, len, div  |  ser, strobe, busy, done
        vecs[0]  = '{1'b0, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'h06, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h06, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h06, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h06, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 8'h0B, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        pattern = 8'h00;
        len     = 4'd0;
        div     = 4'd0;
        loop    = 1'b0;

        // Basic send, back-to-back restart, reset mid-stream and restart.
        for (int i = 0; i < N_VEC; i++) begin
            rst_n   = vecs[i].rst_n;
            start   = vecs[i].start;
            pattern = vecs[i].pattern;
            len     = vecs[i].len;
            div     = vecs[i].div;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ser, vecs[i].exp_stb,
                       vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Divider and clamp, with inputs disturbed mid-send.
        exp_pat = 8'hA5;
        pattern = 8'hA5;
        len     = 4'd15;
        div     = 4'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                check_outs($sformatf("div.b%0d.c%0d", k, c), exp_pat[7-k], (c == 0), 1'b1, 1'b0);
                if (k == 2 && c == 1) start = 1'b1;
                if (k == 3) begin
                    start   = 1'b0;
                    pattern = 8'hFF;
                    div     = 4'd0;
                    len     = 4'd2;
                end
                tick();
            end
        end
        check_outs("div.end", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("div.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // len=0 start is ignored.
        len   = 4'd0;
        start = 1'b1;
        tick();
        check_outs("len0.a", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("len0.b", 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        // Loop mode (single pass when the feature is compiled out).
        loop_bits = 4'b1011;
        pattern   = 8'h0B;
        len       = 4'd4;
        div       = 4'd0;
        loop      = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < N_PASS; p++) begin
            for (int b = 0; b < 4; b++) begin
                check_outs($sformatf("loop.p%0d.b%0d", p, b), loop_bits[3-b], 1'b1, 1'b1,
                           (p != 0 && b == 0));
                if (p == N_PASS - 1 && b == 1) loop = 1'b0;
                tick();
            end
        end
        check_outs("loop.end", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("loop.after", 1'b0, 1'b0, 1'b0, 1'b0);
        loop = 1'b0;

        // Loopback into the detector model.
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        pattern = 8'h0B;
        len     = 4'd4;
        div     = 4'd0;
        start   = 1'b1;
        tick();
        start     = 1'b0;
        flag_hits = 0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("det_flag.t%0d", i), det_flag, (i == 5));
            if (det_flag) flag_hits++;
            tick();
        end
        check("det_hits", flag_hits, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
